// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that drains a byte FIFO with a registered (one-cycle latency) data_out.
// One read is in flight at a time: IDLE raises read_enable, FETCH waits out the latency, LOAD captures.
module fifo_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] fifo_data,
   input  logic       fifo_empty,
   output logic       fifo_read_enable,
   output logic       tx,
   output logic       busy,
   output logic       byte_done
);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StFetch = 3'd1;
   localparam logic [2:0] StLoad  = 3'd2;
   localparam logic [2:0] StStart = 3'd3;
   localparam logic [2:0] StData  = 3'd4;
   localparam logic [2:0] StStop  = 3'd5;

   localparam logic [7:0] CntLast = 8'(CLKS_PER_BIT - 1);

   logic [2:0] state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] clk_cnt_q, clk_cnt_d;
   logic       tx_q, tx_d;
   logic       re_q, re_d;
   logic       busy_q;
   logic       byte_done_q, byte_done_d;
   logic       bit_end;

   assign bit_end = (clk_cnt_q == CntLast);

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      clk_cnt_d   = clk_cnt_q;
      tx_d        = tx_q;
      re_d        = 1'b0;
      byte_done_d = 1'b0;
      case (state_q)
         StIdle: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               re_d    = 1'b1;
               state_d = StFetch;
            end
         end
         // data_out updates on this edge; it is captured one cycle later
         StFetch: state_d = StLoad;
         StLoad: begin
            shift_d   = fifo_data;
            tx_d      = 1'b0;
            clk_cnt_d = 8'd0;
            state_d   = StStart;
         end
         StStart: begin
            if (bit_end) begin
               clk_cnt_d = 8'd0;
               bit_cnt_d = 3'd0;
               tx_d      = shift_q[0];
               state_d   = StData;
            end else begin
               clk_cnt_d = clk_cnt_q + 8'd1;
            end
         end
         StData: begin
            if (bit_end) begin
               clk_cnt_d = 8'd0;
               if (bit_cnt_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = StStop;
               end else begin
                  shift_d   = {1'b0, shift_q[7:1]};
                  tx_d      = shift_q[1];
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 8'd1;
            end
         end
         StStop: begin
            if (bit_end) begin
               clk_cnt_d   = 8'd0;
               byte_done_d = 1'b1;
               state_d     = StIdle;
            end else begin
               clk_cnt_d = clk_cnt_q + 8'd1;
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         shift_q     <= 8'd0;
         bit_cnt_q   <= 3'd0;
         clk_cnt_q   <= 8'd0;
         tx_q        <= 1'b1;
         re_q        <= 1'b0;
         busy_q      <= 1'b0;
         byte_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         clk_cnt_q   <= clk_cnt_d;
         tx_q        <= tx_d;
         re_q        <= re_d;
         busy_q      <= (state_d != StIdle);
         byte_done_q <= byte_done_d;
      end
   end

   assign fifo_read_enable = re_q;
   assign tx               = tx_q;
   assign busy             = busy_q;
   assign byte_done        = byte_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (divisor 8 and 2), each fed by a behavioural FIFO with
// registered data_out/empty; frames are checked cycle by cycle against the ideal 8N1 waveform.
module tb_fifo_uart_tx;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // lane A: CLKS_PER_BIT = 8, lane B: CLKS_PER_BIT = 2
   logic [7:0] a_data = 8'd0, b_data = 8'd0;
   logic       a_empty = 1'b1, b_empty = 1'b1;
   logic       a_re, a_tx, a_busy, a_done;
   logic       b_re, b_tx, b_busy, b_done;

   fifo_uart_tx #(.CLKS_PER_BIT(8)) u_dut_a (
      .clk              (clk),
      .rst_n            (rst_n),
      .fifo_data        (a_data),
      .fifo_empty       (a_empty),
      .fifo_read_enable (a_re),
      .tx               (a_tx),
      .busy             (a_busy),
      .byte_done        (a_done)
   );

   fifo_uart_tx #(.CLKS_PER_BIT(2)) u_dut_b (
      .clk              (clk),
      .rst_n            (rst_n),
      .fifo_data        (b_data),
      .fifo_empty       (b_empty),
      .fifo_read_enable (b_re),
      .tx               (b_tx),
      .busy             (b_busy),
      .byte_done        (b_done)
   );

   // FIFO models: 4 entries, registered data_out and empty flag
   logic [7:0] a_q[$], b_q[$], a_src[$], b_src[$];
   logic       a_push = 1'b0, b_push = 1'b0;
   logic [7:0] a_push_data = 8'd0, b_push_data = 8'd0;
   int         a_underflow = 0, b_underflow = 0;

   always @(posedge clk) begin
      if (a_re) begin
         if (a_empty) a_underflow <= a_underflow + 1;
         else a_data <= a_q.pop_front();
      end
      if (a_push) a_q.push_back(a_push_data);
      a_empty <= (a_q.size() == 0);
      if (b_re) begin
         if (b_empty) b_underflow <= b_underflow + 1;
         else b_data <= b_q.pop_front();
      end
      if (b_push) b_q.push_back(b_push_data);
      b_empty <= (b_q.size() == 0);
   end

   // writer side: moves bytes from the source queues into the FIFO while it has room
   always @(negedge clk) begin
      a_push <= 1'b0;
      if (a_src.size() > 0 && a_q.size() < 4) begin
         a_push      <= 1'b1;
         a_push_data <= a_src.pop_front();
      end
      b_push <= 1'b0;
      if (b_src.size() > 0 && b_q.size() < 4) begin
         b_push      <= 1'b1;
         b_push_data <= b_src.pop_front();
      end
   end

   // protocol monitors
   int   a_re_cnt = 0, b_re_cnt = 0, a_done_cnt = 0, b_done_cnt = 0;
   int   a_re_dbl = 0, b_re_dbl = 0;
   logic a_re_prev = 1'b0, b_re_prev = 1'b0;

   always @(negedge clk) begin
      a_re_prev <= a_re;
      b_re_prev <= b_re;
      if (a_re) a_re_cnt <= a_re_cnt + 1;
      if (b_re) b_re_cnt <= b_re_cnt + 1;
      if (a_re && a_re_prev) a_re_dbl <= a_re_dbl + 1;
      if (b_re && b_re_prev) b_re_dbl <= b_re_dbl + 1;
      if (a_done) a_done_cnt <= a_done_cnt + 1;
      if (b_done) b_done_cnt <= b_done_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic cur_tx(input bit lane);
      return lane ? b_tx : a_tx;
   endfunction

   function automatic logic cur_busy(input bit lane);
      return lane ? b_busy : a_busy;
   endfunction

   function automatic logic cur_done(input bit lane);
      return lane ? b_done : a_done;
   endfunction

   // Called at a negedge. Waits for the start bit, then compares every cycle of the frame with
   // the ideal waveform; returns the idle-high cycles seen before the start bit.
   task automatic expect_frame(input bit lane, input logic [7:0] exp, input int n,
                               output int gap, output logic [19:0] wave);
      int         err;
      int         b;
      bit         seen;
      logic       e;
      logic [7:0] rx;
      gap  = 0;
      seen = 1'b0;
      wave = 20'd0;
      for (int w = 0; w < 3000; w++) begin
         if (cur_tx(lane) == 1'b0) begin
            seen = 1'b1;
            break;
         end
         gap++;
         @(negedge clk);
      end
      check_eq("start_seen", 32'(seen), 32'd1);
      if (!seen) return;
      err = 0;
      rx  = 8'd0;
      for (int i = 0; i < 10 * n; i++) begin
         b = i / n;
         e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp[b-1];
         if (cur_tx(lane) !== e) err++;
         if (cur_done(lane) !== 1'b0 || cur_busy(lane) !== 1'b1) err++;
         if (b >= 1 && b <= 8 && (i % n) == n / 2) rx[b-1] = cur_tx(lane);
         if (i < 20) wave[i] = cur_tx(lane);
         @(negedge clk);
      end
      check_eq("frame_cycles", 32'(err), 32'd0);
      check_eq("frame_byte", 32'(rx), 32'(exp));
      check_eq("byte_done", 32'(cur_done(lane)), 32'd1);
      check_eq("busy_after", 32'(cur_busy(lane)), 32'd0);
   endtask

   initial begin
      int         gap;
      int         lows, busys, re_base, a_frames, b_frames, a_reads, b_reads;
      logic [19:0] wave;
      logic [7:0] four[4];
      logic [7:0] rnd[5];
      bit         seen;
      four     = '{8'h00, 8'hFF, 8'h3C, 8'h81};
      a_frames = 0;
      b_frames = 0;
      a_reads  = 0;
      b_reads  = 0;

      repeat (3) @(negedge clk);
      check_eq("rst_tx", 32'(a_tx), 32'd1);
      check_eq("rst_busy", 32'(a_busy), 32'd0);
      check_eq("rst_re", 32'(a_re), 32'd0);
      check_eq("rst_done", 32'(a_done), 32'd0);
      rst_n = 1'b1;

      // idle with an empty FIFO
      lows  = 0;
      busys = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!a_tx || !b_tx) lows++;
         if (a_busy || b_busy) busys++;
      end
      check_eq("idle_tx_low", 32'(lows), 32'd0);
      check_eq("idle_busy", 32'(busys), 32'd0);
      check_eq("idle_reads", 32'(a_re_cnt + b_re_cnt), 32'd0);

      // single byte
      a_src.push_back(8'hA5);
      expect_frame(1'b0, 8'hA5, 8, gap, wave);
      a_frames++; a_reads++;
      check_eq("a5_reads", 32'(a_re_cnt), 32'(a_reads));

      // four bytes back to back
      for (int k = 0; k < 4; k++) a_src.push_back(four[k]);
      for (int k = 0; k < 4; k++) begin
         expect_frame(1'b0, four[k], 8, gap, wave);
         if (k > 0) check_eq("b2b_gap", 32'(gap), 32'd3);
      end
      a_frames += 4; a_reads += 4;
      check_eq("four_reads", 32'(a_re_cnt), 32'(a_reads));
      check_eq("four_fifo_empty", 32'(a_empty), 32'd1);

      // second byte arrives while the first is on the line
      re_base = a_re_cnt;
      a_src.push_back(8'h96);
      fork
         begin
            repeat (40) @(negedge clk);
            a_src.push_back(8'h4B);
         end
         expect_frame(1'b0, 8'h96, 8, gap, wave);
      join
      check_eq("mid_no_early_read", 32'(a_re_cnt - re_base), 32'd1);
      expect_frame(1'b0, 8'h4B, 8, gap, wave);
      check_eq("mid_gap", 32'(gap), 32'd3);
      a_frames += 2; a_reads += 2;

      // reset during bit 4 of 0x5A
      a_src.push_back(8'h5A);
      seen = 1'b0;
      for (int w = 0; w < 200; w++) begin
         if (!a_tx) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check_eq("rst_frame_start", 32'(seen), 32'd1);
      a_reads++;
      repeat (43) @(negedge clk);
      check_eq("pre_rst_busy", 32'(a_busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("mid_rst_tx", 32'(a_tx), 32'd1);
      check_eq("mid_rst_busy", 32'(a_busy), 32'd0);
      check_eq("mid_rst_re", 32'(a_re), 32'd0);
      repeat (2) @(negedge clk);
      rst_n   = 1'b1;
      re_base = a_re_cnt;
      lows    = 0;
      busys   = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (!a_tx) lows++;
         if (a_busy || a_done) busys++;
      end
      check_eq("post_rst_tx_low", 32'(lows), 32'd0);
      check_eq("post_rst_busy", 32'(busys), 32'd0);
      check_eq("post_rst_reads", 32'(a_re_cnt - re_base), 32'd0);

      // random bytes with random arrival times
      for (int k = 0; k < 5; k++) rnd[k] = 8'($urandom_range(0, 255));
      fork
         begin
            for (int k = 0; k < 5; k++) begin
               repeat ($urandom_range(0, 100)) @(negedge clk);
               a_src.push_back(rnd[k]);
            end
         end
         begin
            for (int k = 0; k < 5; k++) expect_frame(1'b0, rnd[k], 8, gap, wave);
         end
      join
      a_frames += 5; a_reads += 5;

      // minimum divisor
      b_src.push_back(8'h01);
      expect_frame(1'b1, 8'h01, 2, gap, wave);
      check_eq("div2_wave", 32'(wave), 32'h000C000C);
      b_src.push_back(rnd[0] ^ 8'h5C);
      expect_frame(1'b1, rnd[0] ^ 8'h5C, 2, gap, wave);
      b_frames += 2; b_reads += 2;

      repeat (4) @(negedge clk);
      check_eq("a_reads_total", 32'(a_re_cnt), 32'(a_reads));
      check_eq("b_reads_total", 32'(b_re_cnt), 32'(b_reads));
      check_eq("a_done_total", 32'(a_done_cnt), 32'(a_frames));
      check_eq("b_done_total", 32'(b_done_cnt), 32'(b_frames));
      check_eq("re_consecutive", 32'(a_re_dbl + b_re_dbl), 32'd0);
      check_eq("underflow", 32'(a_underflow + b_underflow), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream consumer of the 4-entry byte FIFO.
- Pops one byte at a time using the FIFO's read_enable/empty/data_out protocol and serializes it as an 8N1 UART frame on tx.
- FIFO data_out is registered: it updates on the clock edge after read_enable is sampled high with empty low. This block is built around that one-cycle read latency.

Parameters:
- CLKS_PER_BIT, 8, clk cycles per UART bit period; legal range 2..255.

Ports:
- clk  input  1  system clock (same domain as the FIFO read side)
- rst_n  input  1  asynchronous, active-low reset
- fifo_data  input  8  FIFO data_out
- fifo_empty  input  1  FIFO empty flag
- fifo_read_enable  output  1  registered; drives FIFO read_enable
- tx  output  1  serial line; idles high
- busy  output  1  high whenever state is not IDLE
- byte_done  output  1  one-cycle pulse when a frame's stop bit completes

Behaviour:
- Reset (async, active-low):
  - state=IDLE, tx=1, fifo_read_enable=0, busy=0, byte_done=0.
  - Shift register, bit counter and clock counter are all cleared.
  - Takes effect immediately, even mid-frame. A byte being transmitted at that point is lost.
- State machine: IDLE, FETCH, LOAD, START, DATA, STOP. All outputs are registered.
- IDLE:
  - On an edge with fifo_empty=0: fifo_read_enable<=1, go to FETCH.
  - Otherwise stay in IDLE; tx=1.
- FETCH:
  - fifo_read_enable is high for exactly this one cycle.
  - Next edge: fifo_read_enable<=0, go to LOAD.
- LOAD:
  - fifo_data is now valid. Capture it into an 8-bit shift register.
  - Set tx<=0 and clk_cnt<=0, go to START.
  - fifo_data is ignored in every other state.
- START: tx=0 for CLKS_PER_BIT cycles. When clk_cnt==CLKS_PER_BIT-1:
  - clk_cnt<=0, bit_cnt<=0
  - tx<=shift[0], go to DATA
- DATA:
  - Each bit is held for CLKS_PER_BIT cycles, LSB first.
  - At the end of each bit period, shift right and set tx<=next bit.
  - After bit 7 (bit_cnt==7 at the end of its period): tx<=1, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. At the end of the period: byte_done<=1 for one cycle, go to IDLE.
- Counters:
  - clk_cnt is 8 bits and wraps to 0 at CLKS_PER_BIT-1.
  - bit_cnt is 3 bits.
  - No other arithmetic.
- Frame length: exactly 10*CLKS_PER_BIT cycles with tx in start/data/stop.
- Back-to-back bytes:
  - After STOP, IDLE samples fifo_empty on the next edge.
  - The minimum extra high time between frames is 3 cycles (IDLE, FETCH, LOAD).
  - The FIFO's empty flag has settled by then, so no double pop is possible.
- Underflow: fifo_read_enable is never asserted unless fifo_empty=0 was sampled in IDLE.
- Single outstanding read: at most one read is in flight. fifo_read_enable is never high in two consecutive cycles.
- fifo_empty rising during FETCH is legal; the FIFO guarantees the byte was popped.

Test Plan:
- Reset then idle, fifo_empty=1 for 50 cycles -> tx=1, busy=0, fifo_read_enable never asserted.
- CLKS_PER_BIT=8, one byte 0xA5 pushed -> exactly one read_enable pulse.
  - tx frame: 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1.
  - Each bit lasts 8 cycles; total 80 cycles.
  - byte_done pulses once; busy drops afterwards.
- Four bytes 0x00,0xFF,0x3C,0x81 (FIFO filled to full) -> four frames in order with correct bits.
  - Gap of 3 extra high cycles between consecutive stop bits and start bits.
  - Four read pulses; FIFO empty at the end.
- Byte written while a frame is in progress -> no read_enable until the stop bit ends; the second frame starts 3 cycles after the first stop bit.
- rst_n asserted mid-DATA (bit 4 of 0x5A) -> tx=1, busy=0, fifo_read_enable=0 immediately.
  - After release with fifo_empty=1: line stays idle, no residual frame.
- CLKS_PER_BIT=2, byte 0x01 -> 20-cycle frame with tx pattern 0,0,1,1 followed by 0 for 14 cycles then 1,1.
  - Checks the minimum-divisor boundary.
